// File: rtl/operand_fetch.sv
// Single-entry operand collector: holds one decoded instruction until both sources resolve.
// Define OPFETCH_BYPASS_EN to resolve waiting operands from the snooped write ports in the same cycle.
module operand_fetch #(
  parameter  int unsigned CTL_W = 32,
  localparam int unsigned REG_W = 5,
  localparam int unsigned XLEN  = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [REG_W-1:0] in_rs1,
  input  logic [REG_W-1:0] in_rs2,
  input  logic [REG_W-1:0] in_rd,
  input  logic             in_use_rs1,
  input  logic             in_use_rs2,
  input  logic             in_wb,
  input  logic [CTL_W-1:0] in_ctl,
  output logic [REG_W-1:0] rf_rs1,
  output logic [REG_W-1:0] rf_rs2,
  input  logic             rf_rs1_valid,
  input  logic             rf_rs2_valid,
  input  logic [XLEN-1:0]  rf_rs1_data,
  input  logic [XLEN-1:0]  rf_rs2_data,
  output logic [REG_W-1:0] rf_rd,
  output logic             rf_reserve,
  input  logic [REG_W-1:0] wreg0,
  input  logic [XLEN-1:0]  wdata0,
  input  logic             wen0,
  input  logic [REG_W-1:0] wreg1,
  input  logic [XLEN-1:0]  wdata1,
  input  logic             wen1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_op1,
  output logic [XLEN-1:0]  out_op2,
  output logic [REG_W-1:0] out_rd,
  output logic             out_wb,
  output logic [CTL_W-1:0] out_ctl,
  output logic [XLEN-1:0]  perf_stall
);

  // HELD splits into WAIT/READY combinationally, depending on this cycle's operand resolution
  typedef enum logic {S_EMPTY = 1'b0, S_HELD = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [REG_W-1:0] r_rs1, r_rs2, r_rd;
  logic [REG_W-1:0] w_rs1_nxt, w_rs2_nxt, w_rd_nxt;
  logic             r_use1, r_use2, r_wb;
  logic             w_use1_nxt, w_use2_nxt, w_wb_nxt;
  logic [CTL_W-1:0] r_ctl, w_ctl_nxt;
  logic             r_cap1, r_cap2, w_cap1_nxt, w_cap2_nxt;
  logic [XLEN-1:0]  r_val1, r_val2, w_val1_nxt, w_val2_nxt;
  logic [XLEN-1:0]  r_perf_stall, w_stall_nxt;

  logic             w_hold, w_fire, w_accept;
  logic             w_rdy1, w_rdy2;
  logic [XLEN-1:0]  w_op1, w_op2;
  logic             w_byp1_hit, w_byp2_hit;
  logic [XLEN-1:0]  w_byp1_data, w_byp2_data;

  // Priority resolve: unused/x0, captured, write-port snoop, register file
  function automatic logic [XLEN:0] resolve(
    input logic             used,
    input logic [REG_W-1:0] rs,
    input logic             cap,
    input logic [XLEN-1:0]  val,
    input logic             byp_hit,
    input logic [XLEN-1:0]  byp_data,
    input logic             rfv,
    input logic [XLEN-1:0]  rfd
  );
    logic [XLEN:0] res;
    res = '0;
    if (!used || rs == '0)  res = {1'b1, XLEN'(0)};
    else if (cap)           res = {1'b1, val};
    else if (byp_hit)       res = {1'b1, byp_data};
    else if (rfv)           res = {1'b1, rfd};
    return res;
  endfunction

`ifdef OPFETCH_BYPASS_EN
  // Port 0 wins a same-register collision, as in the register file
  always_comb begin
    w_byp1_hit  = 1'b0;
    w_byp1_data = '0;
    if (wen0 && wreg0 == r_rs1) begin
      w_byp1_hit  = 1'b1;
      w_byp1_data = wdata0;
    end else if (wen1 && wreg1 == r_rs1) begin
      w_byp1_hit  = 1'b1;
      w_byp1_data = wdata1;
    end
  end

  always_comb begin
    w_byp2_hit  = 1'b0;
    w_byp2_data = '0;
    if (wen0 && wreg0 == r_rs2) begin
      w_byp2_hit  = 1'b1;
      w_byp2_data = wdata0;
    end else if (wen1 && wreg1 == r_rs2) begin
      w_byp2_hit  = 1'b1;
      w_byp2_data = wdata1;
    end
  end
`else
  logic w_unused_snoop;
  assign w_unused_snoop = ^{wreg0, wdata0, wen0, wreg1, wdata1, wen1};
  assign w_byp1_hit     = 1'b0;
  assign w_byp1_data    = '0;
  assign w_byp2_hit     = 1'b0;
  assign w_byp2_data    = '0;
`endif

  assign {w_rdy1, w_op1} = resolve(r_use1, r_rs1, r_cap1, r_val1, w_byp1_hit, w_byp1_data,
                                   rf_rs1_valid, rf_rs1_data);
  assign {w_rdy2, w_op2} = resolve(r_use2, r_rs2, r_cap2, r_val2, w_byp2_hit, w_byp2_data,
                                   rf_rs2_valid, rf_rs2_data);

  // Flush suppresses issue so a discarded instruction never reserves its rd
  assign w_hold     = (r_state == S_HELD);
  assign out_valid  = w_hold && w_rdy1 && w_rdy2 && !flush;
  assign w_fire     = out_valid && out_ready;
  assign in_ready   = !flush && (!w_hold || w_fire);
  assign w_accept   = in_valid && in_ready;

  assign out_op1    = w_hold ? w_op1 : '0;
  assign out_op2    = w_hold ? w_op2 : '0;
  assign out_rd     = w_hold ? r_rd  : '0;
  assign out_wb     = w_hold && r_wb;
  assign out_ctl    = w_hold ? r_ctl : '0;
  assign rf_rs1     = w_hold ? r_rs1 : '0;
  assign rf_rs2     = w_hold ? r_rs2 : '0;
  assign rf_rd      = out_rd;
  assign rf_reserve = w_fire && out_wb && (out_rd != '0);
  assign perf_stall = r_perf_stall;

  // Next-state: accept loads, fire/flush empties, a waiting cycle captures resolved operands
  always_comb begin
    w_state_nxt = r_state;
    w_rs1_nxt   = r_rs1;
    w_rs2_nxt   = r_rs2;
    w_rd_nxt    = r_rd;
    w_use1_nxt  = r_use1;
    w_use2_nxt  = r_use2;
    w_wb_nxt    = r_wb;
    w_ctl_nxt   = r_ctl;
    w_cap1_nxt  = r_cap1;
    w_cap2_nxt  = r_cap2;
    w_val1_nxt  = r_val1;
    w_val2_nxt  = r_val2;
    w_stall_nxt = r_perf_stall;

    if (w_hold && !out_valid && !flush) w_stall_nxt = r_perf_stall + XLEN'(1);

    if (w_accept) begin
      w_state_nxt = S_HELD;
      w_rs1_nxt   = in_rs1;
      w_rs2_nxt   = in_rs2;
      w_rd_nxt    = in_rd;
      w_use1_nxt  = in_use_rs1;
      w_use2_nxt  = in_use_rs2;
      w_wb_nxt    = in_wb;
      w_ctl_nxt   = in_ctl;
      w_cap1_nxt  = 1'b0;
      w_cap2_nxt  = 1'b0;
      w_val1_nxt  = '0;
      w_val2_nxt  = '0;
    end else begin
      case (r_state)
        S_HELD: begin
          if (w_fire || flush) begin
            w_state_nxt = S_EMPTY;
          end else begin
            if (w_rdy1 && !r_cap1) begin
              w_cap1_nxt = 1'b1;
              w_val1_nxt = w_op1;
            end
            if (w_rdy2 && !r_cap2) begin
              w_cap2_nxt = 1'b1;
              w_val2_nxt = w_op2;
            end
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_EMPTY;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_use1       <= 1'b0;
      r_use2       <= 1'b0;
      r_wb         <= 1'b0;
      r_ctl        <= '0;
      r_cap1       <= 1'b0;
      r_cap2       <= 1'b0;
      r_val1       <= '0;
      r_val2       <= '0;
      r_perf_stall <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rs1        <= w_rs1_nxt;
      r_rs2        <= w_rs2_nxt;
      r_rd         <= w_rd_nxt;
      r_use1       <= w_use1_nxt;
      r_use2       <= w_use2_nxt;
      r_wb         <= w_wb_nxt;
      r_ctl        <= w_ctl_nxt;
      r_cap1       <= w_cap1_nxt;
      r_cap2       <= w_cap2_nxt;
      r_val1       <= w_val1_nxt;
      r_val2       <= w_val2_nxt;
      r_perf_stall <= w_stall_nxt;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: small register-file model plus an issue scoreboard.
module tb_operand_fetch;
  localparam int unsigned CTL_W = 32;
`ifdef OPFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n, flush, in_valid, in_ready;
  logic [4:0]       in_rs1, in_rs2, in_rd;
  logic             in_use_rs1, in_use_rs2, in_wb;
  logic [CTL_W-1:0] in_ctl;
  logic [4:0]       rf_rs1, rf_rs2, rf_rd;
  logic             rf_rs1_valid, rf_rs2_valid, rf_reserve;
  logic [31:0]      rf_rs1_data, rf_rs2_data;
  logic [4:0]       wreg0, wreg1;
  logic [31:0]      wdata0, wdata1;
  logic             wen0, wen1;
  logic             out_valid, out_ready, out_wb;
  logic [31:0]      out_op1, out_op2, perf_stall;
  logic [4:0]       out_rd;
  logic [CTL_W-1:0] out_ctl;

  typedef struct packed {
    logic [31:0]      op1;
    logic [31:0]      op2;
    logic [4:0]       rd;
    logic             wb;
    logic [CTL_W-1:0] ctl;
    logic             rsv;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_stall;

  logic        tb_init, tb_inv_en;
  logic [4:0]  tb_inv_reg;
  logic        rf_v [32];
  logic [31:0] rf_d [32];

  always #5 clk = ~clk;

  operand_fetch #(.CTL_W(CTL_W)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_wb(in_wb), .in_ctl(in_ctl),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rs1_valid(rf_rs1_valid), .rf_rs2_valid(rf_rs2_valid),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .rf_rd(rf_rd), .rf_reserve(rf_reserve),
    .wreg0(wreg0), .wdata0(wdata0), .wen0(wen0),
    .wreg1(wreg1), .wdata1(wdata1), .wen1(wen1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_wb(out_wb), .out_ctl(out_ctl),
    .perf_stall(perf_stall)
  );

  // Register file with scoreboard bits; port 0 written last so it wins collisions
  assign rf_rs1_valid = rf_v[rf_rs1];
  assign rf_rs2_valid = rf_v[rf_rs2];
  assign rf_rs1_data  = rf_d[rf_rs1];
  assign rf_rs2_data  = rf_d[rf_rs2];

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 32; i++) begin
        rf_v[i] <= 1'b1;
        rf_d[i] <= 32'(i) * 32'h11;
      end
    end else begin
      if (rf_reserve && rf_rd != 5'd0) rf_v[rf_rd] <= 1'b0;
      if (tb_inv_en) rf_v[tb_inv_reg] <= 1'b0;
      if (wen1 && wreg1 != 5'd0) begin
        rf_v[wreg1] <= 1'b1;
        rf_d[wreg1] <= wdata1;
      end
      if (wen0 && wreg0 != 5'd0) begin
        rf_v[wreg0] <= 1'b1;
        rf_d[wreg0] <= wdata0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Issue monitor: every handshake pops one expected instruction
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset_n === 1'b1) begin
      if (out_valid && out_ready) begin
        chk("sb_pending_at_issue", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("issue_op1", 64'(out_op1), 64'(e.op1));
          chk("issue_op2", 64'(out_op2), 64'(e.op2));
          chk("issue_rd", 64'(out_rd), 64'(e.rd));
          chk("issue_wb", 64'(out_wb), 64'(e.wb));
          chk("issue_ctl", 64'(out_ctl), 64'(e.ctl));
          chk("issue_reserve", 64'(rf_reserve), 64'(e.rsv));
          if (e.rsv) chk("issue_rf_rd", 64'(rf_rd), 64'(e.rd));
        end
      end else begin
        chk("reserve_without_issue", 64'(rf_reserve), 64'd0);
      end
    end
  end

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; tb_inv_en = 1'b0;
    wen0 = 1'b0; wreg0 = 5'd0; wdata0 = 32'd0;
    wen1 = 1'b0; wreg1 = 5'd0; wdata1 = 32'd0;
  endtask

  task automatic offer(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic wb, input logic [31:0] ctl);
    in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_use_rs1 = u1; in_use_rs2 = u2; in_wb = wb; in_ctl = ctl;
  endtask

  task automatic expect_issue(input logic [31:0] op1, input logic [31:0] op2, input logic [4:0] rd,
                              input logic wb, input logic [31:0] ctl, input logic rsv);
    exp_t e;
    e.op1 = op1; e.op2 = op2; e.rd = rd; e.wb = wb; e.ctl = ctl; e.rsv = rsv;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; tb_init = 1'b1; tb_inv_reg = 5'd0; idle();
    offer(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0); in_valid = 1'b0;
    exp_stall = 0;
    repeat (2) @(posedge clk);
    #1; mid();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_reserve", 64'(rf_reserve), 64'd0);
    chk("rst_rf_rs1", 64'(rf_rs1), 64'd0);
    chk("rst_rf_rs2", 64'(rf_rs2), 64'd0);
    chk("rst_op1", 64'(out_op1), 64'd0);
    chk("rst_op2", 64'(out_op2), 64'd0);
    chk("rst_perf", 64'(perf_stall), 64'd0);
    cyc(); tb_init = 1'b0; reset_n = 1'b1;

    // Asynchronous reset while an instruction waits on x9
    tb_inv_en = 1'b1; tb_inv_reg = 5'd9; mid(); cyc();
    idle(); offer(5'd9, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 32'hB0);
    mid(); chk("b_accept", 64'(in_ready), 64'd1); cyc();
    idle(); mid();
    chk("b_wait_valid", 64'(out_valid), 64'd0);
    chk("b_wait_rf_rs1", 64'(rf_rs1), 64'd9);
    chk("b_perf0", 64'(perf_stall), 64'd0);
    cyc();
    mid(); chk("b_perf1", 64'(perf_stall), 64'd1); cyc();
    reset_n = 1'b0; #1;
    chk("b_rst_in_ready", 64'(in_ready), 64'd1);
    chk("b_rst_out_valid", 64'(out_valid), 64'd0);
    chk("b_rst_perf", 64'(perf_stall), 64'd0);
    chk("b_rst_reserve", 64'(rf_reserve), 64'd0);
    chk("b_rst_rf_rs1", 64'(rf_rs1), 64'd0);
    cyc(); reset_n = 1'b1;

    // No-hazard stream: one issue per cycle
    for (int k = 0; k < 4; k++) begin
      idle();
      offer(5'd1, 5'd2, 5'(10 + k), 1'b1, 1'b1, 1'b1, 32'h100 + 32'(k));
      expect_issue(32'h11, 32'h22, 5'(10 + k), 1'b1, 32'h100 + 32'(k), 1'b1);
      mid();
      chk("c_in_ready", 64'(in_ready), 64'd1);
      if (k == 0) chk("c_latency", 64'(out_valid), 64'd0);
      else        chk("c_stream_valid", 64'(out_valid), 64'd1);
      cyc();
    end
    idle(); mid(); chk("c_last_valid", 64'(out_valid), 64'd1); cyc();
    idle(); mid();
    chk("c_drained", 64'(out_valid), 64'd0);
    chk("c_perf", 64'(perf_stall), 64'(exp_stall));
    cyc();

    // RAW: A reserves x5, B reads x5, port-0 write arrives later
    idle(); offer(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 32'hA0);
    expect_issue(32'h11, 32'h22, 5'd5, 1'b1, 32'hA0, 1'b1);
    mid(); cyc();
    idle(); offer(5'd5, 5'd2, 5'd6, 1'b1, 1'b1, 1'b1, 32'hB1);
    expect_issue(32'hDEAD, 32'h22, 5'd6, 1'b1, 32'hB1, 1'b1);
    mid();
    chk("d_a_issue", 64'(out_valid), 64'd1);
    chk("d_b_accept", 64'(in_ready), 64'd1);
    cyc();
    for (int c = 0; c < 3; c++) begin
      idle(); mid(); chk("d_b_wait", 64'(out_valid), 64'd0); cyc();
    end
    idle(); wen0 = 1'b1; wreg0 = 5'd5; wdata0 = 32'hDEAD;
    mid(); chk("d_bypass_issue", 64'(out_valid), 64'(BYP)); cyc();
    idle(); mid(); chk("d_rf_issue", 64'(out_valid), 64'(!BYP)); cyc();
    exp_stall += BYP ? 3 : 4;
    idle(); mid(); chk("d_perf", 64'(perf_stall), 64'(exp_stall)); cyc();

    // Both write ports hit x7 in one cycle: port 0 value wins
    idle(); tb_inv_en = 1'b1; tb_inv_reg = 5'd7;
    offer(5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 32'hE0);
    expect_issue(32'hA, 32'h0, 5'd8, 1'b0, 32'hE0, 1'b0);
    mid(); cyc();
    idle(); mid(); chk("e_wait", 64'(out_valid), 64'd0); cyc();
    idle(); wen0 = 1'b1; wreg0 = 5'd7; wdata0 = 32'hA; wen1 = 1'b1; wreg1 = 5'd7; wdata1 = 32'hB;
    mid(); chk("e_bypass_issue", 64'(out_valid), 64'(BYP)); cyc();
    idle(); mid(); chk("e_rf_issue", 64'(out_valid), 64'(!BYP)); cyc();
    exp_stall += BYP ? 1 : 2;

    // Back-pressure: op1 captured early, later write to x20 must not leak in
    idle(); tb_inv_en = 1'b1; tb_inv_reg = 5'd20; mid(); cyc();
    idle(); tb_inv_en = 1'b1; tb_inv_reg = 5'd21; mid(); cyc();
    idle(); offer(5'd20, 5'd21, 5'd22, 1'b1, 1'b1, 1'b1, 32'hF0);
    expect_issue(32'h5, 32'h77, 5'd22, 1'b1, 32'hF0, 1'b1);
    mid(); chk("f_accept", 64'(in_ready), 64'd1); cyc();
    for (int c = 1; c <= 5; c++) begin
      idle(); out_ready = (c == 5);
      offer(5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1, 32'hF1);
      if (c == 1) begin
        expect_issue(32'h11, 32'h22, 5'd0, 1'b1, 32'hF1, 1'b0);
        wen0 = 1'b1; wreg0 = 5'd20; wdata0 = 32'h5;
      end
      if (c == 3) begin wen1 = 1'b1; wreg1 = 5'd21; wdata1 = 32'h77; end
      if (c == 4) begin wen0 = 1'b1; wreg0 = 5'd20; wdata0 = 32'h9; end
      mid();
      if (c < 5) chk("f_in_ready_blocked", 64'(in_ready), 64'd0);
      else       chk("f_issue_accept", 64'(in_ready), 64'd1);
      if (c >= 4) chk("f_ready_held", 64'(out_valid), 64'd1);
      if (c == 4) chk("f_op1_captured", 64'(out_op1), 64'h5);
      cyc();
    end
    idle(); mid(); chk("f_rd0_issue", 64'(out_valid), 64'd1); cyc();
    exp_stall += BYP ? 2 : 3;

    // Flush while waiting, then an rs1=x0 instruction
    idle(); offer(5'd9, 5'd0, 5'd14, 1'b1, 1'b0, 1'b1, 32'hC0); mid(); cyc();
    idle(); mid(); chk("g_wait", 64'(out_valid), 64'd0); cyc();
    idle(); flush = 1'b1; wen0 = 1'b1; wreg0 = 5'd9; wdata0 = 32'h99;
    offer(5'd0, 5'd2, 5'd15, 1'b1, 1'b1, 1'b1, 32'hC1);
    expect_issue(32'h0, 32'h22, 5'd15, 1'b1, 32'hC1, 1'b1);
    mid();
    chk("g_flush_in_ready", 64'(in_ready), 64'd0);
    chk("g_flush_valid", 64'(out_valid), 64'd0);
    cyc();
    idle(); offer(5'd0, 5'd2, 5'd15, 1'b1, 1'b1, 1'b1, 32'hC1);
    mid();
    chk("g_after_flush_ready", 64'(in_ready), 64'd1);
    chk("g_after_flush_valid", 64'(out_valid), 64'd0);
    cyc();
    idle(); mid(); chk("g_x0_issue", 64'(out_valid), 64'd1); cyc();
    exp_stall += 1;
    idle(); mid();
    chk("final_perf", 64'(perf_stall), 64'(exp_stall));
    chk("sb_drained", 64'(sb.size()), 64'd0);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
